// File: rtl/usb_pkg.sv
// Shared constants and types for the USB data buffer.
package usb_pkg;

    localparam int USB_BUF_DEPTH = 64;
    localparam int USB_OCC_W     = 7;

    // Sticky error flags reported to the AHB status register.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic collision;
    } usb_flags_t;

endpackage

// File: rtl/usb_buffer_ctrl.sv
// Pointer, occupancy, arbitration and sticky-flag control for the USB byte FIFO.
module usb_buffer_ctrl
    import usb_pkg::*;
#(
    parameter int DEPTH = USB_BUF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push_rx,
    input  logic                 push_tx,
    input  logic                 pop_tx,
    input  logic                 pop_rx,
    output logic                 wr_en,
    output logic [AW-1:0]        waddr,
    output logic [AW-1:0]        raddr,
    output logic [USB_OCC_W-1:0] count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 collision
);

    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [USB_OCC_W-1:0] cnt;
    usb_flags_t           flags;

    logic push;
    logic pop;
    logic push_acc;
    logic pop_acc;

    // Arbitrate the two producers and two consumers and decide what is accepted.
    always_comb begin
        // NOTE: every always_comb output is assigned unconditionally first so no latch is inferred.
        push     = push_rx | push_tx;
        pop      = pop_tx | pop_rx;
        pop_acc  = pop && (cnt != '0);
        push_acc = push && ((cnt < USB_OCC_W'(DEPTH)) || pop_acc);
        wr_en    = push_acc && !clear;
    end

    // Advance pointers and occupancy; clear overrides any traffic in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_acc) wptr <= wptr + AW'(1);
            if (pop_acc)  rptr <= rptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + USB_OCC_W'(1);
                2'b01:   cnt <= cnt - USB_OCC_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; only reset or clear can drop them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (clear) begin
            flags <= '0;
        end else begin
            if (push && !push_acc)                      flags.overflow  <= 1'b1;
            if (pop && !pop_acc)                        flags.underflow <= 1'b1;
            if ((push_rx && push_tx) || (pop_tx && pop_rx)) flags.collision <= 1'b1;
        end
    end

    assign waddr     = wptr;
    assign raddr     = rptr;
    assign count     = cnt;
    assign overflow  = flags.overflow;
    assign underflow = flags.underflow;
    assign collision = flags.collision;

endmodule

// File: rtl/usb_data_buffer.sv
// Byte-wide show-ahead FIFO shared by the AHB slave and the USB receiver/transmitter.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = USB_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store_tx_data,
    input  logic [7:0]           tx_data,
    input  logic                 get_rx_data,
    output logic [7:0]           rx_data,
    input  logic                 clear,
    input  logic                 store_rx_packet_data,
    input  logic [7:0]           rx_packet_data,
    input  logic                 get_tx_packet_data,
    output logic [7:0]           tx_packet_data,
    output logic [USB_OCC_W-1:0] buffer_occupancy,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 collision
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [7:0]    wdata;
    logic [7:0]    head;

    usb_buffer_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push_rx   (store_rx_packet_data),
        .push_tx   (store_tx_data),
        .pop_tx    (get_tx_packet_data),
        .pop_rx    (get_rx_data),
        .wr_en     (wr_en),
        .waddr     (waddr),
        .raddr     (raddr),
        .count     (buffer_occupancy),
        .overflow  (overflow),
        .underflow (underflow),
        .collision (collision)
    );

    // The receiver byte wins when both producers strobe together.
    assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;

    // Storage array; written only on an accepted push, untouched by clear.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this array is reset on purpose so no stale byte can ever leave after reset; it costs flops, not RAM.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead head byte, forced to zero whenever the FIFO is empty.
    always_comb begin
        head = 8'h00;
        if (buffer_occupancy != '0) head = mem[raddr];
    end

    assign rx_data        = head;
    assign tx_packet_data = head;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: pops queue expected head bytes, a monitor compares them.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       clear = 1'b0;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;
    logic       underflow;
    logic       collision;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q [$];

    usb_data_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .clear                (clear),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow),
        .collision            (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Monitor: every pop strobe seen mid-cycle consumes one expected head byte.
    always @(negedge clk) begin
        if (!rst && (get_rx_data || get_tx_packet_data)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_queue: pop strobe with no expected byte queued");
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (get_rx_data)        check("rx_data_head", {24'h0, rx_data}, {24'h0, e});
                if (get_tx_packet_data) check("tx_packet_head", {24'h0, tx_packet_data}, {24'h0, e});
            end
        end
    end

    // One clock cycle of stimulus; strobes are dropped again just after the edge.
    task automatic cycle(input logic srx, input logic [7:0] drx, input logic stx, input logic [7:0] dtx,
                         input logic grx, input logic gtx, input logic [7:0] exp_head, input logic clr);
        store_rx_packet_data = srx;
        rx_packet_data       = drx;
        store_tx_data        = stx;
        tx_data              = dtx;
        get_rx_data          = grx;
        get_tx_packet_data   = gtx;
        clear                = clr;
        if (grx || gtx) exp_q.push_back(exp_head);
        @(posedge clk);
        #1;
        store_rx_packet_data = 1'b0;
        store_tx_data        = 1'b0;
        get_rx_data          = 1'b0;
        get_tx_packet_data   = 1'b0;
        clear                = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] d); cycle(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); endtask
    task automatic push_tx(input logic [7:0] d); cycle(1'b0, 8'h00, 1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0); endtask
    task automatic pop_rx(input logic [7:0] e);  cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, e, 1'b0); endtask
    task automatic pop_tx(input logic [7:0] e);  cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, e, 1'b0); endtask
    task automatic do_clear();                   cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1); endtask

    task automatic check_status(input string tag, input int occ, input logic ov, input logic un, input logic co);
        check({tag, "_occ"},       32'(buffer_occupancy), 32'(occ));
        check({tag, "_overflow"},  32'(overflow),  32'(ov));
        check({tag, "_underflow"}, 32'(underflow), 32'(un));
        check({tag, "_collision"}, 32'(collision), 32'(co));
    endtask

    // Watchdog: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_status("in_reset", 0, 1'b0, 1'b0, 1'b0);
        check("in_reset_rx_data", 32'(rx_data), 32'h0);
        check("in_reset_tx_data", 32'(tx_packet_data), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status("after_reset", 0, 1'b0, 1'b0, 1'b0);

        // Receiver pushes three bytes, AHB pops them back-to-back.
        push_rx(8'h11);
        push_rx(8'h22);
        push_rx(8'h33);
        check_status("three", 3, 1'b0, 1'b0, 1'b0);
        check("three_head", 32'(rx_data), 32'h11);
        pop_rx(8'h11);
        pop_rx(8'h22);
        pop_rx(8'h33);
        check_status("drained", 0, 1'b0, 1'b0, 1'b0);
        check("drained_rx_data", 32'(rx_data), 32'h0);

        // Fill from AHB, then one push too many.
        for (int i = 0; i < 64; i++) push_tx(8'(i));
        check_status("full", 64, 1'b0, 1'b0, 1'b0);
        push_tx(8'hAA);
        check_status("overflowed", 64, 1'b1, 1'b0, 1'b0);

        // Full FIFO: push and pop together keep it full.
        cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0);
        check_status("full_pushpop", 64, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 64; i++) pop_tx(8'(i));
        check("last_is_55", 32'(tx_packet_data), 32'h55);
        pop_tx(8'h55);
        check_status("emptied", 0, 1'b1, 1'b0, 1'b0);
        do_clear();
        check_status("clear1", 0, 1'b0, 1'b0, 1'b0);

        // Empty FIFO: pop is refused, simultaneous push still lands.
        cycle(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        check_status("underflowed", 1, 1'b0, 1'b1, 1'b0);
        check("underflow_head", 32'(rx_data), 32'h77);
        pop_rx(8'h77);
        do_clear();
        check_status("clear2", 0, 1'b0, 1'b0, 1'b0);

        // Both producers at once: receiver byte wins.
        cycle(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
        check_status("push_coll", 1, 1'b0, 1'b0, 1'b1);
        check("push_coll_head", 32'(tx_packet_data), 32'h01);
        push_rx(8'h03);
        // Both consumers at once: a single entry leaves.
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0);
        check_status("pop_coll", 1, 1'b0, 1'b0, 1'b1);
        check("pop_coll_head", 32'(rx_data), 32'h03);
        pop_tx(8'h03);
        do_clear();
        check_status("clear3", 0, 1'b0, 1'b0, 1'b0);

        // Pointer wrap: 40 in, 30 out, 50 more in.
        for (int k = 0; k < 40; k++) push_rx(8'(8'h80 + k));
        for (int k = 0; k < 30; k++) pop_rx(8'(8'h80 + k));
        for (int k = 40; k < 90; k++) push_tx(8'(8'h80 + k));
        check_status("wrapped", 60, 1'b0, 1'b0, 1'b0);
        for (int k = 30; k < 50; k++) pop_tx(8'(8'h80 + k));
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80 + 8'd50, 1'b0);
        check_status("mid_stream", 39, 1'b0, 1'b0, 1'b1);
        check("mid_stream_head", 32'(rx_data), 32'h80 + 32'd51);
        do_clear();
        check_status("clear_mid", 0, 1'b0, 1'b0, 1'b0);
        check("clear_mid_head", 32'(tx_packet_data), 32'h0);

        // Reset pulse in the middle of a burst empties the FIFO at once.
        push_rx(8'hE1);
        push_rx(8'hE2);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'hE3;
        #2;
        rst = 1'b1;
        #1;
        check_status("mid_reset", 0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_rx_data", 32'(rx_data), 32'h0);
        check("mid_reset_tx_data", 32'(tx_packet_data), 32'h0);
        store_rx_packet_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_rx(8'h99);
        check_status("fresh", 1, 1'b0, 1'b0, 1'b0);
        check("fresh_head", 32'(rx_data), 32'h99);
        pop_rx(8'h99);
        check_status("final", 0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_leftover: got %0d queued, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
